// File: rtl/scoreboard_pkg.sv
// Shared scoreboard types and constants.
// Used by the shot clock, score accumulator and BCD converter.
package scoreboard_pkg;

    localparam int CNT_W     = 7;
    localparam int FULL_DEF  = 24;
    localparam int SHORT_DEF = 14;

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } shot_state_t;

endpackage

// File: rtl/shot_clock_ctrl_if.sv
// Shot clock control/status bundle.
// The master drives run/reload; the slave reports count and flags.
interface shot_clock_ctrl_if;
    import scoreboard_pkg::*;

    logic             run;
    logic             reload_full;
    logic             reload_short;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             running;
    logic             expired;
    logic             buzzer;

    modport master (
        output run, reload_full, reload_short,
        input  count, tick, running, expired, buzzer
    );

    modport slave (
        input  run, reload_full, reload_short,
        output count, tick, running, expired, buzzer
    );

endinterface

// File: rtl/shot_tick_gen.sv
// 1 Hz prescaler: wraps at TICK_DIV-1 and emits a registered tick.
// clr beats en and also swallows a wrap on the same edge.
module shot_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic gate,
    output logic wrap,
    output logic tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc;

    assign wrap = en & ~clr & (presc == PW'(TICK_DIV - 1));

    // Prescaler counts while enabled; frozen otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= wrap & gate;
            if (clr)
                presc <= '0;
            else if (en)
                presc <= wrap ? '0 : presc + 1'b1;
        end
    end

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot clock controller: reloadable 24/14 s countdown with buzzer.
// Holds the state machine, reload edge detect and buzz counter.
module shot_clock_ctrl
    import scoreboard_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int FULL_VAL   = FULL_DEF,
    parameter int SHORT_VAL  = SHORT_DEF,
    parameter int BUZZ_TICKS = 2
) (
    input  logic             clk,
    input  logic             reset,
    shot_clock_ctrl_if.slave sc
);

    localparam int BW = (BUZZ_TICKS > 1) ? $clog2(BUZZ_TICKS + 1) : 1;

    shot_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             buzz_q, buzz_d;
    logic             full_prev, short_prev;
    logic             full_ev, short_ev, reload;
    logic             wrap;

    assign full_ev  = sc.reload_full & ~full_prev;
    assign short_ev = sc.reload_short & ~short_prev;
    assign reload   = full_ev | short_ev;

    shot_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state_q != STOP),
        .clr   (reload),
        .gate  ((state_q == RUN) | buzz_q),
        .wrap  (wrap),
        .tick  (sc.tick)
    );

    // State, count, buzzer and button history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= STOP;
            count_q    <= CNT_W'(FULL_VAL);
            bcnt_q     <= '0;
            buzz_q     <= 1'b0;
            full_prev  <= 1'b0;
            short_prev <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            bcnt_q     <= bcnt_d;
            buzz_q     <= buzz_d;
            full_prev  <= sc.reload_full;
            short_prev <= sc.reload_short;
        end
    end

    // Next state: reloads first, then per-state countdown/buzz.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bcnt_d  = bcnt_q;
        buzz_d  = buzz_q;
        if (full_ev) begin
            state_d = STOP;
            count_d = CNT_W'(FULL_VAL);
            bcnt_d  = '0;
            buzz_d  = 1'b0;
        end else if (short_ev) begin
            state_d = STOP;
            count_d = CNT_W'(SHORT_VAL);
            bcnt_d  = '0;
            buzz_d  = 1'b0;
        end else begin
            case (state_q)
                STOP: begin
                    if (sc.run && count_q != '0)
                        state_d = RUN;
                end
                RUN: begin
                    if (!sc.run)
                        state_d = STOP;
                    if (wrap && count_q != '0) begin
                        count_d = count_q - 1'b1;
                        if (count_q == CNT_W'(1)) begin
                            state_d = EXPIRED;
                            buzz_d  = 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    if (wrap && buzz_q) begin
                        bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == BW'(BUZZ_TICKS - 1))
                            buzz_d = 1'b0;
                    end
                end
                default: state_d = STOP;
            endcase
        end
    end

    assign sc.count   = count_q;
    assign sc.running = (state_q == RUN);
    assign sc.expired = (state_q == EXPIRED);
    assign sc.buzzer  = buzz_q;

endmodule
